// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding-mux selects, result sources,
// and the nearest-stage forwarding priority function.
package hazard_ctrl_pkg;

    localparam logic [2:0] SEL_RF   = 3'b000;
    localparam logic [2:0] SEL_MALU = 3'b001;
    localparam logic [2:0] SEL_WD   = 3'b010;
    localparam logic [2:0] SEL_MPC  = 3'b011;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_DM  = 2'b01;
    localparam logic [1:0] RES_PC8 = 2'b10;

    // A load still in M (tnew 1) is skipped here; the stall logic keeps consumers away from it.
    function automatic logic [2:0] fwd_sel(input logic [4:0] src,
                                           input logic       use_m,
                                           input logic [4:0] a3_m,
                                           input logic [1:0] tnew_m,
                                           input logic [1:0] res_m,
                                           input logic [4:0] a3_w);
        logic [2:0] sel;
        sel = SEL_RF;
        if (src != 5'd0) begin
            if (use_m && src == a3_m && tnew_m == 2'd0)
                sel = (res_m == RES_PC8) ? SEL_MPC : SEL_MALU;
            else if (src == a3_w)
                sel = SEL_WD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage decode information in, forwarding selects and stall out.
interface hazard_ctrl_if;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       use_rs_d;
    logic       use_rt_d;
    logic [1:0] tuse_rs_d;
    logic [1:0] tuse_rt_d;
    logic [4:0] a3_d;
    logic [1:0] tnew_d;
    logic [1:0] res_d;
    logic       stall;
    logic [2:0] mf_d_1_sel;
    logic [2:0] mf_d_2_sel;
    logic [2:0] mf_alu_a_sel;
    logic [2:0] mf_alu_b_sel;
    logic [2:0] mf_dmi_sel;

    modport master (
        output rs_d, rt_d, use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d, a3_d, tnew_d, res_d,
        input  stall, mf_d_1_sel, mf_d_2_sel, mf_alu_a_sel, mf_alu_b_sel, mf_dmi_sel
    );

    modport slave (
        input  rs_d, rt_d, use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d, a3_d, tnew_d, res_d,
        output stall, mf_d_1_sel, mf_d_2_sel, mf_alu_a_sel, mf_alu_b_sel, mf_dmi_sel
    );
endinterface

// File: rtl/hazard_ctrl_slot.sv
// One shadow pipeline slot: destination, remaining Tnew and result source of an in-flight instruction.
module hazard_slot (
    input  logic       clk,
    input  logic       reset,
    input  logic       bubble,
    input  logic       dec,
    input  logic [4:0] a3_in,
    input  logic [1:0] tnew_in,
    input  logic [1:0] res_in,
    output logic [4:0] a3,
    output logic [1:0] tnew,
    output logic [1:0] res
);
    logic [1:0] tnew_nxt;

    assign tnew_nxt = (dec && tnew_in != 2'd0) ? tnew_in - 2'd1 : (dec ? 2'd0 : tnew_in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a3   <= 5'd0;
            tnew <= 2'd0;
            res  <= 2'd0;
        end else if (bubble) begin
            a3   <= 5'd0;
            tnew <= 2'd0;
            res  <= 2'd0;
        end else begin
            a3   <= a3_in;
            tnew <= tnew_nxt;
            res  <= res_in;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: stall generation and forwarding-mux selects,
// driven by shadow E/M/W slots that advance in lockstep with the datapath.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    logic [4:0] a3_e, a3_m, a3_w;
    logic [1:0] tnew_e, tnew_m, tnew_w;
    logic [1:0] res_e, res_m, res_w;
    logic [4:0] rs_e, rt_e, rt_m;
    logic       stall_rs, stall_rt;
    logic       unused_w;

    hazard_slot u_slot_e (
        .clk(clk), .reset(reset), .bubble(hz.stall), .dec(1'b0),
        .a3_in(hz.a3_d), .tnew_in(hz.tnew_d), .res_in(hz.res_d),
        .a3(a3_e), .tnew(tnew_e), .res(res_e)
    );

    hazard_slot u_slot_m (
        .clk(clk), .reset(reset), .bubble(1'b0), .dec(1'b1),
        .a3_in(a3_e), .tnew_in(tnew_e), .res_in(res_e),
        .a3(a3_m), .tnew(tnew_m), .res(res_m)
    );

    hazard_slot u_slot_w (
        .clk(clk), .reset(reset), .bubble(1'b0), .dec(1'b1),
        .a3_in(a3_m), .tnew_in(tnew_m), .res_in(res_m),
        .a3(a3_w), .tnew(tnew_w), .res(res_w)
    );

    // W only matters as a register-file write-back source, so its tnew/res are not consumed.
    assign unused_w = ^{tnew_w, res_w};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_e <= 5'd0;
            rt_e <= 5'd0;
            rt_m <= 5'd0;
        end else begin
            rs_e <= hz.stall ? 5'd0 : hz.rs_d;
            rt_e <= hz.stall ? 5'd0 : hz.rt_d;
            rt_m <= rt_e;
        end
    end

    assign stall_rs = hz.use_rs_d && (hz.rs_d != 5'd0) &&
                      ((hz.rs_d == a3_e && tnew_e > hz.tuse_rs_d) ||
                       (hz.rs_d == a3_m && tnew_m > hz.tuse_rs_d));
    assign stall_rt = hz.use_rt_d && (hz.rt_d != 5'd0) &&
                      ((hz.rt_d == a3_e && tnew_e > hz.tuse_rt_d) ||
                       (hz.rt_d == a3_m && tnew_m > hz.tuse_rt_d));
    assign hz.stall = stall_rs | stall_rt;

    assign hz.mf_d_1_sel   = fwd_sel(hz.rs_d, 1'b1, a3_m, tnew_m, res_m, a3_w);
    assign hz.mf_d_2_sel   = fwd_sel(hz.rt_d, 1'b1, a3_m, tnew_m, res_m, a3_w);
    assign hz.mf_alu_a_sel = fwd_sel(rs_e,    1'b1, a3_m, tnew_m, res_m, a3_w);
    assign hz.mf_alu_b_sel = fwd_sel(rt_e,    1'b1, a3_m, tnew_m, res_m, a3_w);
    assign hz.mf_dmi_sel   = fwd_sel(rt_m,    1'b0, a3_m, tnew_m, res_m, a3_w);
endmodule
